// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: default widths and the
// encoding of the next-PC source selected by the priority mux.
package pc_unit_pkg;

    localparam int PC_WIDTH_DEF = 16;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [2:0] {
        PC_SRC_HOLD,
        PC_SRC_INC,
        PC_SRC_BRANCH,
        PC_SRC_CALL,
        PC_SRC_RET,
        PC_SRC_CALLRET
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO of RAS_DEPTH entries. A push onto a
// full stack overwrites the oldest entry. Replace swaps the top entry (tail
// call), and becomes a push when the stack is empty. Overflow, underflow and
// replace-on-empty set a sticky error flag. State updates on falling clk.
module pc_ras #(
    parameter int PC_WIDTH  = 16,
    parameter int RAS_DEPTH = 4,
    localparam int PW = $clog2(RAS_DEPTH),
    localparam int CW = $clog2(RAS_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                replace,
    input  logic [PC_WIDTH-1:0] wdata,
    output logic [PC_WIDTH-1:0] top,
    output logic [CW-1:0]       count,
    output logic                empty,
    output logic                full,
    output logic                err
);

    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);

    logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]       wr_ptr;   // slot the next push writes
    logic [PW-1:0]       top_ptr;  // most recent entry
    logic [PW-1:0]       wr_ptr_inc;
    logic                do_push;
    logic                do_replace;

    assign top_ptr    = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
    assign wr_ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
    assign empty      = (count == '0);
    assign full       = (count == CW'(RAS_DEPTH));
    assign top        = mem[top_ptr];
    assign do_push    = push | (replace & empty);
    assign do_replace = replace & ~empty;

    // Pointer, occupancy and sticky error; a full push keeps count and
    // lets the write pointer overrun the oldest slot.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr_inc;
            if (!full)
                count <= count + CW'(1);
            if (full || replace)
                err <= 1'b1;
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                wr_ptr <= top_ptr;
                count  <= count - CW'(1);
            end
        end
    end

    // Entry storage; contents are meaningless while count says empty.
    always_ff @(negedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
        else if (do_replace)
            mem[top_ptr] <= wdata;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, incrementer and next-PC priority mux
// (stall > call&ret > ret > call > branch > increment). State updates on the
// falling edge of clk. Define PC_UNIT_RAS_EN to build in the return-address
// stack; without it call acts as a branch, ret as an increment and the RAS
// flags are tied to empty / not full / no error.
import pc_unit_pkg::*;

module pc_unit #(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int RESET_PC  = RESET_PC_DEF,
    parameter int PC_INC    = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                call,
    input  logic                ret,
    output logic [PC_WIDTH-1:0] current_PC,
    output logic [PC_WIDTH-1:0] next_PC,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_err
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_has_entry;
    pc_src_e             src;

    assign pc_inc     = pc_q + PC_WIDTH'(PC_INC);
    assign current_PC = pc_q;

    // Resolve the control inputs into a single next-PC source by priority.
    always_comb begin
        src = PC_SRC_INC;
        if (stall)
            src = PC_SRC_HOLD;
        else if (call && ret)
            src = PC_SRC_CALLRET;
        else if (ret)
            src = PC_SRC_RET;
        else if (call)
            src = PC_SRC_CALL;
        else if (branch_taken)
            src = PC_SRC_BRANCH;
    end

    // Next-PC mux; a return with nothing on the stack falls through to +INC.
    always_comb begin
        next_PC = pc_inc;
        case (src)
            PC_SRC_HOLD:    next_PC = pc_q;
            PC_SRC_BRANCH,
            PC_SRC_CALL,
            PC_SRC_CALLRET: next_PC = branch_target;
            PC_SRC_RET:     next_PC = ras_has_entry ? ras_top : pc_inc;
            default:        next_PC = pc_inc;
        endcase
    end

    // PC register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= PC_WIDTH'(RESET_PC);
        else
            pc_q <= next_PC;
    end

`ifdef PC_UNIT_RAS_EN
    logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;

    pc_ras #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (src == PC_SRC_CALL),
        .pop     (src == PC_SRC_RET),
        .replace (src == PC_SRC_CALLRET),
        .wdata   (pc_inc),
        .top     (ras_top),
        .count   (ras_count),
        .empty   (ras_empty),
        .full    (ras_full),
        .err     (ras_err)
    );

    assign ras_has_entry = (ras_count != '0);
`else
    assign ras_top       = '0;
    assign ras_has_entry = 1'b0;
    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
    assign ras_err       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: constant vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
// Expectations follow PC_UNIT_RAS_EN the same way the design build does.
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, call, ret;
    logic [15:0] branch_target;
    logic [15:0] current_PC, next_PC;
    logic        ras_empty, ras_full, ras_err;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_q[$];
    logic        m_err;

    pc_unit #(.PC_WIDTH(16), .RESET_PC(0), .PC_INC(1), .RAS_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call          (call),
        .ret           (ret),
        .current_PC    (current_PC),
        .next_PC       (next_PC),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_q.delete();
        m_err = 1'b0;
    endtask

    // Apply one cycle of controls to the model; returns the PC it will load.
    task automatic model_step(input logic s, b, c, r, input logic [15:0] t,
                              output logic [15:0] nx);
        logic [15:0] inc;
        inc = m_pc + 16'd1;
`ifdef PC_UNIT_RAS_EN
        if (s) nx = m_pc;
        else if (c && r) begin
            nx = t;
            if (m_q.size() == 0) begin m_q.push_back(inc); m_err = 1'b1; end
            else m_q[m_q.size()-1] = inc;
        end else if (r) begin
            if (m_q.size() == 0) begin nx = inc; m_err = 1'b1; end
            else nx = m_q.pop_back();
        end else if (c) begin
            if (m_q.size() == DEPTH) begin void'(m_q.pop_front()); m_err = 1'b1; end
            m_q.push_back(inc);
            nx = t;
        end else if (b) nx = t;
        else nx = inc;
`else
        if (s) nx = m_pc;
        else if (c) nx = t;
        else if (r) nx = inc;
        else if (b) nx = t;
        else nx = inc;
`endif
        m_pc = nx;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pc"}, current_PC, m_pc);
`ifdef PC_UNIT_RAS_EN
        chk({tag, "_empty"}, ras_empty, m_q.size() == 0);
        chk({tag, "_full"},  ras_full,  m_q.size() == DEPTH);
        chk({tag, "_err"},   ras_err,   m_err);
`else
        chk({tag, "_empty"}, ras_empty, 1'b1);
        chk({tag, "_full"},  ras_full,  1'b0);
        chk({tag, "_err"},   ras_err,   1'b0);
`endif
    endtask

    // One clock: drive in the high phase, check next_PC, check state after
    // the falling edge.
    task automatic step(input logic s, b, c, r, input logic [15:0] t);
        logic [15:0] exp_nx;
        @(posedge clk); #1;
        stall = s; branch_taken = b; call = c; ret = r; branch_target = t;
        model_step(s, b, c, r, t, exp_nx);
        #1 chk("next_PC", next_PC, exp_nx);
        @(negedge clk); #1;
        check_state("step");
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_state("async_rst");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        s, b, c, r;
        logic [15:0] t;
        logic [15:0] pc;
        logic        emp;
    } vec_t;

`ifdef PC_UNIT_RAS_EN
    localparam logic [15:0] RET_PC   = 16'h0011;
    localparam logic        CALL_EMP = 1'b0;
    logic [15:0] exp_ret[5] = '{16'h0051, 16'h0041, 16'h0031, 16'h0021, 16'h0022};
`else
    localparam logic [15:0] RET_PC   = 16'h0106;
    localparam logic        CALL_EMP = 1'b1;
    logic [15:0] exp_ret[5] = '{16'h0061, 16'h0062, 16'h0063, 16'h0064, 16'h0065};
`endif

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0010, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100, CALL_EMP};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0105, 16'h0105, CALL_EMP};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, RET_PC,   1'b1};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0777, RET_PC,   1'b1};

        stall = 0; branch_taken = 0; call = 0; ret = 0; branch_target = '0;
        rst_n = 1'b0;
        model_reset();
        #3 check_state("reset");
        #9 rst_n = 1'b1;

        // constant vector table
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].s, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].t);
            chk($sformatf("tbl%0d_pc", i), current_PC, tbl[i].pc);
            chk($sformatf("tbl%0d_empty", i), ras_empty, tbl[i].emp);
        end

        // reset mid-run with no clock edge
        async_reset();

        // five nested calls, then five returns
        step(0, 1, 0, 0, 16'h0010);
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 0, 16'h0020 + 16'(i) * 16'h0010);
`ifdef PC_UNIT_RAS_EN
        chk("nest_full", ras_full, 1'b1);
        chk("nest_err",  ras_err,  1'b1);
`else
        chk("nest_full", ras_full, 1'b0);
        chk("nest_err",  ras_err,  1'b0);
`endif
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 16'h0F00);
            chk($sformatf("nest_ret%0d", i), current_PC, exp_ret[i]);
        end

        // tail call on empty then non-empty stack
        async_reset();
        step(0, 0, 1, 1, 16'h0300);
        step(0, 0, 1, 1, 16'h0400);
        step(0, 0, 0, 1, 16'h0000);
        step(0, 0, 0, 1, 16'h0000);

        // randomized traffic
        async_reset();
        for (int n = 0; n < 400; n++) begin
            logic s, b, c, r;
            s = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 2) == 0);
            step(s, b, c, r, 16'($urandom));
            if (n % 97 == 96) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the processor front end, superseding the fixed 16-bit PC register. It holds the current PC and selects the next PC from increment, branch/jump target, or a hardware return-address stack (RAS) for call/return. It also supports stall. Instruction memory addresses from `current_PC`; decode/branch logic drives the control inputs.

## Interface
- `PC_WIDTH`, 16: PC width in bits.
- `RESET_PC`, 0: value loaded on reset.
- `PC_INC`, 1: sequential increment step; addressing is word-addressed.
- `RAS_DEPTH`, 4: number of return-address entries; must be ≥2.
- `clk` in 1: the only clock; all state updates on the falling edge of `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the PC and the RAS.
- `branch_taken` in 1: load `branch_target`.
- `branch_target` in `PC_WIDTH`: jump, branch or call destination.
- `call` in 1: push the return address and load `branch_target`.
- `ret` in 1: pop the RAS top into the PC.
- `current_PC` out `PC_WIDTH`: registered PC.
- `next_PC` out `PC_WIDTH`: combinational value that the next falling edge will load.
- `ras_empty` out 1: RAS holds 0 entries.
- `ras_full` out 1: RAS holds `RAS_DEPTH` entries.
- `ras_err` out 1: sticky flag for overflow or underflow. Cleared only by reset.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - `current_PC`=`RESET_PC`.
  - RAS count=0, so `ras_empty`=1 and `ras_full`=0.
  - `ras_err`=0.
  - Outputs hold these values until the first falling edge after `rst_n` rises.
- Next-PC priority, highest first:
  1. `stall`
  2. `call`&`ret`
  3. `ret`
  4. `call`
  5. `branch_taken`
  6. increment
- Hold: `next_PC`=`current_PC`. RAS unchanged.
- Increment: `next_PC`=`current_PC`+`PC_INC`, modulo 2^`PC_WIDTH`. 0xFFFF+1 wraps to 0x0000.
- Branch: `next_PC`=`branch_target`.
- Call:
  - `next_PC`=`branch_target`.
  - Push `current_PC`+`PC_INC` (wrapped).
  - If the RAS is full, the oldest entry is dropped (circular buffer), count stays `RAS_DEPTH`, and `ras_err` is set.
- Ret, RAS not empty: `next_PC`=top entry; pop.
- Ret, RAS empty: `next_PC`=`current_PC`+`PC_INC`, no pop, `ras_err` set.
- `call`&`ret` together (tail call):
  - `next_PC`=`branch_target`.
  - Top entry is replaced by `current_PC`+`PC_INC`; count unchanged.
  - If the RAS is empty, this is a plain push and `ras_err` is set.
- `branch_taken` is ignored when `call` or `ret` is asserted.

## Timing
- Single-cycle latency: controls sampled at a falling edge determine `current_PC` from that edge.
- `next_PC` is combinational from the controls and state. Stall affects the same edge.
- `ras_empty`/`ras_full` reflect the post-update count, registered.
- `ras_err` asserts on the edge that commits the offending operation.
- Reset asserted mid-operation clears the PC, RAS and flags immediately, regardless of the clock. Any pending push or pop is discarded.

## Configuration
- `PC_UNIT_RAS_EN` defined: RAS and `ras_err` logic are compiled in, as described above.
- `PC_UNIT_RAS_EN` undefined:
  - No RAS storage.
  - `call` behaves as `branch_taken`.
  - `ret` behaves as increment.
  - `call`&`ret` behaves as branch.
  - `ras_empty`=1, `ras_full`=0, `ras_err`=0 constantly.

## Structure
- Shared package `pc_unit_pkg`:
  - default `PC_WIDTH`
  - `RESET_PC`
  - next-PC source encoding `PC_SRC_HOLD`, `PC_SRC_INC`, `PC_SRC_BRANCH`, `PC_SRC_CALL`, `PC_SRC_RET`, `PC_SRC_CALLRET`
- One sub-module `pc_ras`:
  - circular LIFO, `RAS_DEPTH` × `PC_WIDTH`
  - push/pop/replace ports, count, empty/full, err
  - instantiated only under `PC_UNIT_RAS_EN`
- Top level holds the priority mux, the incrementer and the PC register.

## Test plan
- Reset then 3 free edges: `current_PC` 0x0000→0x0001→0x0002→0x0003. `rst_n` low mid-run returns 0x0000 with no clock edge.
- `current_PC`=0xFFFF, increment: next `current_PC`=0x0000, no flag change.
- At PC 0x0010, `call` with target 0x0100. Then `ret` at 0x0105: PC goes 0x0100, then 0x0011. `ras_empty` goes 1→0→1.
- `RAS_DEPTH`=4: 5 nested calls from 0x10,0x20,0x30,0x40,0x50. `ras_full`=1 and `ras_err`=1. 4 returns yield 0x51,0x41,0x31,0x21. 5th return increments the PC.
- `stall`=1 with `call`=1 and `branch_taken`=1: PC and RAS unchanged. `next_PC`=`current_PC`.
- Build without `PC_UNIT_RAS_EN`: `call` to 0x0200 loads 0x0200; `ret` increments. Flags remain constant 1/0/0.
